// File: rtl/dcache_sram_nway_pkg.sv
// Shared defaults and types for the N-way dcache storage array.
// The line-state age field is sized for the largest supported associativity (8 ways).
package dcache_pkg;
  localparam int DEF_WAYS   = 4;
  localparam int DEF_SETS   = 16;
  localparam int DEF_TAG_W  = 25;
  localparam int DEF_LINE_W = 256;
  localparam int MAX_AGE_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_AGE_W-1:0] age;
  } line_state_t;
endpackage

// File: rtl/dcache_sram_nway_if.sv
// Access/flush bus between the dcache controller (master) and the storage array (slave).
interface dcache_sram_nway_if #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 25,
  parameter int LINE_W = 256,
  parameter int WAY_W  = 2
);
  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              dirty_i;
  logic              flush_i;
  logic              hit_o;
  logic [WAY_W-1:0]  way_o;
  logic [TAG_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              valid_o;
  logic              dirty_o;
  logic              busy_o;

  modport master (
    output addr_i, tag_i, data_i, enable_i, write_i, dirty_i, flush_i,
    input  hit_o, way_o, tag_o, data_o, valid_o, dirty_o, busy_o
  );

  modport slave (
    input  addr_i, tag_i, data_i, enable_i, write_i, dirty_i, flush_i,
    output hit_o, way_o, tag_o, data_o, valid_o, dirty_o, busy_o
  );
endinterface

// File: rtl/dcache_sram_nway_lru.sv
// True-LRU helper for one set: picks the victim way and computes ages after touching a way.
// Purely combinational; age 0 is MRU and ages form a permutation of 0..WAYS-1.
module dcache_lru #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 3,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAY_W-1:0]           touch_i,
  output logic [WAY_W-1:0]           victim_o,
  output logic [WAYS-1:0][AGE_W-1:0] age_o
);
  logic             found;
  logic [AGE_W-1:0] touch_age;

  // Invalid ways are preferred over evicting live data; lowest index wins.
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w] == AGE_W'(WAYS - 1)) begin
          victim_o = WAY_W'(w);
        end
      end
    end
  end

  always_comb begin
    touch_age = age_i[touch_i];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touch_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < touch_age) begin
        age_o[w] = age_i[w] + AGE_W'(1);
      end else begin
        age_o[w] = age_i[w];
      end
    end
  end
endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU, valid/dirty state and a flush sweep.
// Lookup is zero-latency combinational; updates land on the clock edge; accesses dropped while busy_o.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input logic              clk_i,
  input logic              rst_i,
  dcache_sram_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  line_state_t       st_q   [SETS][WAYS];
  flush_state_e      state_q;
  logic [IDX_W-1:0]  cnt_q;

  logic                              busy;
  logic                              hit;
  logic                              accept;
  logic                              do_touch;
  logic                              flush_go;
  logic [WAYS-1:0]                   set_valid;
  logic [WAYS-1:0]                   match;
  logic [WAYS-1:0][MAX_AGE_W-1:0]    set_age;
  logic [WAYS-1:0][MAX_AGE_W-1:0]    next_age;
  logic [WAY_W-1:0]                  hit_way;
  logic [WAY_W-1:0]                  victim_way;
  logic [WAY_W-1:0]                  sel_way;

  assign busy = (state_q == SWEEP);

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign set_valid[w] = st_q[bus.addr_i][w].valid;
    assign set_age[w]   = st_q[bus.addr_i][w].age;
    assign match[w]     = set_valid[w] && (tag_q[bus.addr_i][w] == bus.tag_i) && !busy;
  end

  // Tags are unique within a set, so OR-ing indices is a valid one-hot encoder.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) begin
        hit_way = hit_way | WAY_W'(w);
      end
    end
  end

  dcache_lru #(
    .WAYS  (WAYS),
    .AGE_W (MAX_AGE_W)
  ) u_lru (
    .age_i    (set_age),
    .valid_i  (set_valid),
    .touch_i  (sel_way),
    .victim_o (victim_way),
    .age_o    (next_age)
  );

  assign hit      = |match;
  assign sel_way  = hit ? hit_way : victim_way;
  assign flush_go = bus.flush_i && !busy;
  assign accept   = bus.enable_i && !busy && !bus.flush_i;
  assign do_touch = accept && (hit || bus.write_i);

  assign bus.hit_o   = hit;
  assign bus.way_o   = sel_way;
  assign bus.tag_o   = tag_q[bus.addr_i][sel_way];
  assign bus.data_o  = data_q[bus.addr_i][sel_way];
  assign bus.valid_o = st_q[bus.addr_i][sel_way].valid;
  assign bus.dirty_o = st_q[bus.addr_i][sel_way].dirty;
  assign bus.busy_o  = busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          st_q[s][w]   <= '{valid: 1'b0, dirty: 1'b0, age: MAX_AGE_W'(w)};
        end
      end
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_go) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            st_q[cnt_q][w].valid <= 1'b0;
            st_q[cnt_q][w].dirty <= 1'b0;
          end
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(SETS - 1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Never overlaps the sweep: accept requires the FSM to be idle.
      if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          st_q[bus.addr_i][w].age <= next_age[w];
        end
        if (bus.write_i) begin
          data_q[bus.addr_i][sel_way] <= bus.data_i;
          if (hit) begin
            st_q[bus.addr_i][sel_way].dirty <= st_q[bus.addr_i][sel_way].dirty | bus.dirty_i;
          end else begin
            tag_q[bus.addr_i][sel_way]      <= bus.tag_i;
            st_q[bus.addr_i][sel_way].valid <= 1'b1;
            st_q[bus.addr_i][sel_way].dirty <= bus.dirty_i;
          end
        end
      end
    end
  end
endmodule
